// File: rtl/sc_scbc_gsr.sv
// Global system register block for the SCBC: version, control/soft-reset, interrupt status/enable,
// scratch and a 64-bit timestamp with a coherent low/high read.
//   state   | meaning
//   S_IDLE  | no soft reset in progress, SRST writes accepted
//   S_PULSE | SOFT_RST asserted, down-counter running, SRST writes ignored
module sc_scbc_gsr #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter logic [31:0] VERSION     = 32'h0001_0000,
  parameter int unsigned INT_NUM     = 8,
  parameter int unsigned SRST_CYCLES = 16
) (
  input  logic                  SYSCLK,
  input  logic                  SYSRSTB,
  input  logic                  SYS_WENB,
  input  logic [ADDR_WIDTH-1:0] WADR,
  input  logic [31:0]           WDAT,
  input  logic [3:0]            WENB,
  input  logic                  SYS_RENB,
  input  logic [ADDR_WIDTH-1:0] RADR,
  output logic [31:0]           GSR_RDAT,
  input  logic [INT_NUM-1:0]    INT_SRC,
  output logic                  IRQ,
  output logic                  SOFT_RST
);

  localparam logic [5:0] A_VER     = 6'h00;
  localparam logic [5:0] A_CTRL    = 6'h01;
  localparam logic [5:0] A_INTSTS  = 6'h02;
  localparam logic [5:0] A_INTENB  = 6'h03;
  localparam logic [5:0] A_SCRATCH = 6'h04;
  localparam logic [5:0] A_TSL     = 6'h05;
  localparam logic [5:0] A_TSH     = 6'h06;
  localparam logic [7:0] SRST_LOAD = 8'(SRST_CYCLES - 1);

  typedef enum logic {S_IDLE, S_PULSE} state_t;

  state_t              state_q, state_d;
  logic [7:0]          srst_cnt_q, srst_cnt_d;
  logic                srst_start;
  logic                gie_q;
  logic [INT_NUM-1:0]  intenb_q;
  logic [INT_NUM-1:0]  intsts_q;
  logic [INT_NUM-1:0]  src_q;
  logic [INT_NUM-1:0]  int_rise;
  logic [INT_NUM-1:0]  int_clr;
  logic [31:0]         scratch_q;
  logic [63:0]         ts_cnt;
  logic [31:0]         tsh_q;
  logic [31:0]         rdat_q;
  logic [31:0]         rd_word;
  logic                irq_q;
  logic [31:0]         wmask;
  logic                we_ctrl, we_intsts, we_intenb, we_scratch;
  logic                srst_req;
  logic                rd_tsl;
  logic                unused_addr;

  // Address bits outside [7:2] are deliberately ignored (aliasing).
  assign unused_addr = ^{WADR, RADR};

  assign wmask      = {{8{WENB[3]}}, {8{WENB[2]}}, {8{WENB[1]}}, {8{WENB[0]}}};
  assign we_ctrl    = SYS_WENB && (WADR[7:2] == A_CTRL);
  assign we_intsts  = SYS_WENB && (WADR[7:2] == A_INTSTS);
  assign we_intenb  = SYS_WENB && (WADR[7:2] == A_INTENB);
  assign we_scratch = SYS_WENB && (WADR[7:2] == A_SCRATCH);
  assign srst_req   = we_ctrl && WENB[0] && WDAT[0];
  assign rd_tsl     = SYS_RENB && (RADR[7:2] == A_TSL);

  always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      state_q    <= S_IDLE;
      srst_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      srst_cnt_q <= srst_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    srst_cnt_d = srst_cnt_q;
    srst_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (srst_req) begin
          state_d    = S_PULSE;
          srst_cnt_d = SRST_LOAD;
          srst_start = 1'b1;
        end
      end
      S_PULSE: begin
        if (srst_cnt_q == 8'd0) state_d = S_IDLE;
        else                    srst_cnt_d = srst_cnt_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign SOFT_RST = (state_q == S_PULSE);

  // Set (rising edge) takes priority over a same-cycle W1C clear.
  assign int_rise = INT_SRC & ~src_q;
  assign int_clr  = we_intsts ? (WDAT[INT_NUM-1:0] & wmask[INT_NUM-1:0]) : '0;

  always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      src_q    <= '0;
      intsts_q <= '0;
      intenb_q <= '0;
      gie_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      src_q <= INT_SRC;
      if (srst_start) intsts_q <= '0;
      else            intsts_q <= (intsts_q & ~int_clr) | int_rise;
      if (we_intenb)
        intenb_q <= (intenb_q & ~wmask[INT_NUM-1:0]) | (WDAT[INT_NUM-1:0] & wmask[INT_NUM-1:0]);
      if (we_ctrl && WENB[1]) gie_q <= WDAT[8];
      irq_q <= gie_q & (|(intsts_q & intenb_q));
    end
  end

  assign IRQ = irq_q;

  always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      scratch_q <= 32'd0;
    end else if (we_scratch) begin
      scratch_q <= (scratch_q & ~wmask) | (WDAT & wmask);
    end
  end

  // The TSL read captures the upper half so a following TSH read is coherent.
  always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      ts_cnt <= 64'd0;
      tsh_q  <= 32'd0;
    end else begin
      if (srst_start) ts_cnt <= 64'd0;
      else            ts_cnt <= ts_cnt + 64'd1;
      if (srst_start)  tsh_q <= 32'd0;
      else if (rd_tsl) tsh_q <= ts_cnt[63:32];
    end
  end

  always_comb begin
    rd_word = 32'd0;
    case (RADR[7:2])
      A_VER:     rd_word = VERSION;
      A_CTRL:    rd_word = {23'd0, gie_q, 7'd0, SOFT_RST};
      A_INTSTS:  rd_word = 32'(intsts_q);
      A_INTENB:  rd_word = 32'(intenb_q);
      A_SCRATCH: rd_word = scratch_q;
      A_TSL:     rd_word = ts_cnt[31:0];
      A_TSH:     rd_word = tsh_q;
      default:   rd_word = 32'd0;
    endcase
  end

  always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
    if (!SYSRSTB)      rdat_q <= 32'd0;
    else if (SYS_RENB) rdat_q <= rd_word;
  end

  assign GSR_RDAT = rdat_q;

endmodule

// File: tb/tb_sc_scbc_gsr.sv
// Bench for sc_scbc_gsr: directed register traffic, reads checked by a scoreboard monitor,
// IRQ/SOFT_RST levels checked inline.
module tb_sc_scbc_gsr;

  localparam logic [31:0] A_VER     = 32'h00;
  localparam logic [31:0] A_CTRL    = 32'h04;
  localparam logic [31:0] A_INTSTS  = 32'h08;
  localparam logic [31:0] A_INTENB  = 32'h0C;
  localparam logic [31:0] A_SCRATCH = 32'h10;
  localparam logic [31:0] A_TSL     = 32'h14;
  localparam logic [31:0] A_TSH     = 32'h18;

  logic        SYSCLK = 1'b0;
  logic        SYSRSTB;
  logic        SYS_WENB;
  logic [31:0] WADR;
  logic [31:0] WDAT;
  logic [3:0]  WENB;
  logic        SYS_RENB;
  logic [31:0] RADR;
  logic [31:0] GSR_RDAT;
  logic [7:0]  INT_SRC;
  logic        IRQ;
  logic        SOFT_RST;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  sc_scbc_gsr dut (
    .SYSCLK   (SYSCLK),
    .SYSRSTB  (SYSRSTB),
    .SYS_WENB (SYS_WENB),
    .WADR     (WADR),
    .WDAT     (WDAT),
    .WENB     (WENB),
    .SYS_RENB (SYS_RENB),
    .RADR     (RADR),
    .GSR_RDAT (GSR_RDAT),
    .INT_SRC  (INT_SRC),
    .IRQ      (IRQ),
    .SOFT_RST (SOFT_RST)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted read strobe yields one registered result.
  always @(posedge SYSCLK) begin
    if (SYSRSTB && SYS_RENB) begin
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected: got %h expected no read", GSR_RDAT);
      end else begin
        mon_e = exp_q.pop_front();
        check(mon_e.name, 64'(GSR_RDAT), 64'(mon_e.exp));
      end
    end
  end

  task automatic push_exp(input logic [31:0] exp, input string name);
    exp_t e;
    e.exp  = exp;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    SYS_WENB = 1'b1; WADR = a; WDAT = d; WENB = be;
    @(negedge SYSCLK);
    SYS_WENB = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    SYS_RENB = 1'b1; RADR = a;
    push_exp(exp, name);
    @(negedge SYSCLK);
    SYS_RENB = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    SYSRSTB = 1'b0; SYS_WENB = 1'b0; WADR = '0; WDAT = '0; WENB = '0;
    SYS_RENB = 1'b0; RADR = '0; INT_SRC = '0;
    repeat (2) @(negedge SYSCLK);
    check("rst_rdat", 64'(GSR_RDAT), 64'h0);
    check("rst_irq", 64'(IRQ), 64'h0);
    check("rst_srst", 64'(SOFT_RST), 64'h0);
    SYSRSTB = 1'b1;
    @(negedge SYSCLK);

    rd(A_VER, 32'h0001_0000, "ver");
    rd(32'h20, 32'h0, "unmapped");
    rd(A_CTRL, 32'h0, "ctrl_rst");
    rd(A_INTSTS, 32'h0, "intsts_rst");
    rd(A_TSH, 32'h0, "tsh_rst");
    wr(A_VER, 32'hDEAD_BEEF, 4'hF);
    rd(A_VER, 32'h0001_0000, "ver_ro");

    wr(A_SCRATCH, 32'hA5A5_A5A5, 4'b0101);
    rd(A_SCRATCH, 32'h00A5_00A5, "scratch_be0101");
    wr(A_SCRATCH, 32'h1234_5678, 4'b1010);
    rd(A_SCRATCH | 32'h3, 32'h12A5_56A5, "scratch_be1010");
    SYS_WENB = 1'b1; WADR = A_SCRATCH; WDAT = 32'hFFFF_FFFF; WENB = 4'hF;
    rd(A_SCRATCH, 32'h12A5_56A5, "scratch_rw_same");
    SYS_WENB = 1'b0;
    rd(A_SCRATCH, 32'hFFFF_FFFF, "scratch_after_rw");

    wr(A_INTENB, 32'hFFFF_FFFF, 4'hF);
    rd(A_INTENB, 32'h0000_00FF, "intenb_width");
    wr(A_INTENB, 32'h0000_0001, 4'hF);
    wr(A_CTRL, 32'h0000_0100, 4'b0010);
    rd(A_CTRL, 32'h0000_0100, "ctrl_gie");

    INT_SRC = 8'h01;
    @(negedge SYSCLK);
    check("irq_lag", 64'(IRQ), 64'h0);
    INT_SRC = 8'h00;
    @(negedge SYSCLK);
    check("irq_set", 64'(IRQ), 64'h1);
    rd(A_INTSTS, 32'h01, "intsts_set");
    wr(A_INTSTS, 32'h01, 4'b0001);
    check("irq_hold", 64'(IRQ), 64'h1);
    @(negedge SYSCLK);
    check("irq_clr", 64'(IRQ), 64'h0);
    rd(A_INTSTS, 32'h00, "intsts_clr");

    INT_SRC = 8'h01;
    wr(A_INTSTS, 32'h01, 4'b0001);
    INT_SRC = 8'h00;
    rd(A_INTSTS, 32'h01, "intsts_set_wins");
    wr(A_INTSTS, 32'hFF, 4'b1110);
    rd(A_INTSTS, 32'h01, "intsts_be_gated");
    INT_SRC = 8'h04;
    @(negedge SYSCLK);
    rd(A_INTSTS, 32'h05, "intsts_bit2");
    wr(A_INTSTS, 32'h05, 4'b0001);
    rd(A_INTSTS, 32'h00, "intsts_level_held");
    INT_SRC = 8'h00;

    force dut.ts_cnt = 64'h0000_0000_FFFF_FFFE;
    release dut.ts_cnt;
    rd(A_TSL, 32'hFFFF_FFFE, "tsl_pre_wrap");
    repeat (4) @(negedge SYSCLK);
    rd(A_TSH, 32'h0, "tsh_snapshot");
    rd(A_TSL, 32'h4, "tsl_post_wrap");
    rd(A_TSH, 32'h1, "tsh_after");

    INT_SRC = 8'h01;
    @(negedge SYSCLK);
    INT_SRC = 8'h00;
    @(negedge SYSCLK);
    check("irq_pre_srst", 64'(IRQ), 64'h1);

    wr(A_CTRL, 32'h0000_0101, 4'b0011);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (SOFT_RST) n++;
      SYS_WENB = (i == 5); WADR = A_CTRL; WDAT = 32'h0000_0101; WENB = 4'b0011;
      SYS_RENB = (i == 1) || (i == 2);
      RADR = (i == 1) ? A_TSH : A_TSL;
      if (i == 1) push_exp(32'h0, "tsh_srst_clr");
      if (i == 2) push_exp(32'h2, "tsl_srst_restart");
      @(negedge SYSCLK);
    end
    SYS_WENB = 1'b0; SYS_RENB = 1'b0;
    check("srst_len", 64'(n), 64'd16);
    check("irq_after_srst", 64'(IRQ), 64'h0);
    rd(A_INTSTS, 32'h0, "intsts_srst");
    rd(A_CTRL, 32'h0000_0100, "gie_kept");
    rd(A_INTENB, 32'h01, "intenb_kept");
    rd(A_SCRATCH, 32'hFFFF_FFFF, "scratch_kept");

    wr(A_CTRL, 32'h0000_0101, 4'b0011);
    INT_SRC = 8'h01;
    @(negedge SYSCLK);
    INT_SRC = 8'h00;
    @(negedge SYSCLK);
    check("irq_in_pulse", 64'(IRQ), 64'h1);
    check("srst_in_pulse", 64'(SOFT_RST), 64'h1);
    rd(A_SCRATCH, 32'hFFFF_FFFF, "scratch_pre_rst");
    #2;
    SYSRSTB = 1'b0;
    #1;
    check("async_srst", 64'(SOFT_RST), 64'h0);
    check("async_irq", 64'(IRQ), 64'h0);
    check("async_rdat", 64'(GSR_RDAT), 64'h0);
    @(negedge SYSCLK);
    SYSRSTB = 1'b1;
    @(negedge SYSCLK);
    rd(A_CTRL, 32'h0, "ctrl_after_rst");
    rd(A_INTENB, 32'h0, "intenb_after_rst");
    rd(A_SCRATCH, 32'h0, "scratch_after_rst");
    rd(A_INTSTS, 32'h0, "intsts_after_rst");
    rd(A_TSH, 32'h0, "tsh_after_rst");

    repeat (2) @(negedge SYSCLK);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
